// File: rtl/mem_pkg.sv
// Shared definitions for the multi-cycle memory responder: word and
// byte-offset widths, the wait-counter width and the handshake state type.
package mem_pkg;

    localparam int WORD_W   = 32;
    localparam int OFFSET_W = 2;
    localparam int CNT_W    = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mem_array.sv
// Single-port synchronous RAM. A write stores wdata at idx; a read loads
// rdata from idx on the edge where re is high, and rdata holds otherwise.
module mem_array
    import mem_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] idx,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [2**ADDR_W];

    // Storage write port.
    // NOTE: the storage array has no reset; clearing every word is not needed and would block RAM inference.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= wdata;
        end
    end

    // Registered read data: cleared by reset, updated only on a read commit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[idx];
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Multi-cycle memory slave answering the CPU's MemRd/MemWr/Addr/W_data
// interface with a request/Ready handshake and WAIT_CYCLES wait states.
// Optional misalignment reporting on Err is built when MEM_ALIGN_CHECK_EN
// is defined; otherwise the byte offset is dropped and there is no Err port.
module mem_responder
    import mem_pkg::*;
#(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        MemRd,
    input  logic        MemWr,
    input  logic [31:0] Addr,
    input  logic [31:0] W_data,
    output logic [31:0] R_data,
    output logic        Ready
`ifdef MEM_ALIGN_CHECK_EN
    ,
    output logic        Err
`endif
);

    localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_CYCLES);
    localparam bit               NO_WAIT   = (WAIT_CYCLES == 0);

    state_t              state;
    state_t              next_state;
    logic [CNT_W-1:0]    cnt;
    logic                req;
    logic [ADDR_W-1:0]   live_idx;
    logic                op_wr_q;
    logic [ADDR_W-1:0]   idx_q;
    logic [WORD_W-1:0]   wdata_q;
    logic                commit;
    logic                commit_wr;
    logic [ADDR_W-1:0]   commit_idx;
    logic [WORD_W-1:0]   commit_wdata;
    logic                mem_we;
    logic                mem_re;
    logic                unused_addr_bits;

    assign req      = MemRd | MemWr;
    assign live_idx = Addr[ADDR_W+OFFSET_W-1:OFFSET_W];

    // Upper address bits alias onto the array; the byte offset only matters
    // for the alignment check.
    assign unused_addr_bits = ^{Addr[31:ADDR_W+OFFSET_W], Addr[OFFSET_W-1:0]};

`ifdef MEM_ALIGN_CHECK_EN
    logic misalign_q;
    logic commit_mis;
    logic err_q;
`endif

    // State register, wait counter and the request copy taken at accept.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            op_wr_q <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
        end else begin
            state <= next_state;
            if (state == IDLE && req) begin
                cnt     <= WAIT_INIT;
                op_wr_q <= MemWr;
                idx_q   <= live_idx;
                wdata_q <= W_data;
            end else if (state == WAIT) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    // Next-state logic: accept in IDLE, count down in WAIT, one cycle of DONE.
    // NOTE: next_state gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (req) next_state = NO_WAIT ? DONE : WAIT;
            WAIT:    if (cnt <= CNT_W'(1)) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Outputs and commit controls. With no wait states the commit edge is the
    // accept edge, so the live request is used instead of the latched copy.
    always_comb begin
        commit       = 1'b0;
        commit_wr    = op_wr_q;
        commit_idx   = idx_q;
        commit_wdata = wdata_q;
`ifdef MEM_ALIGN_CHECK_EN
        commit_mis   = misalign_q;
`endif
        if (state == IDLE) begin
            commit       = req && NO_WAIT;
            commit_wr    = MemWr;
            commit_idx   = live_idx;
            commit_wdata = W_data;
`ifdef MEM_ALIGN_CHECK_EN
            commit_mis   = |Addr[OFFSET_W-1:0];
`endif
        end else if (state == WAIT) begin
            commit = (cnt <= CNT_W'(1));
        end
        // A write takes priority when both requests are raised together.
        mem_we = rst_n && commit && commit_wr;
        mem_re = rst_n && commit && !commit_wr;
`ifdef MEM_ALIGN_CHECK_EN
        mem_we = mem_we && !commit_mis;
        mem_re = mem_re && !commit_mis;
`endif
        Ready = (state == DONE);
    end

`ifdef MEM_ALIGN_CHECK_EN
    // Misalignment copy at accept and the Err flag raised for the DONE cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            misalign_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            if (state == IDLE && req) begin
                misalign_q <= |Addr[OFFSET_W-1:0];
            end
            err_q <= commit && commit_mis;
        end
    end

    assign Err = err_q;
`endif

    mem_array #(
        .ADDR_W (ADDR_W)
    ) u_mem_array (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (mem_we),
        .re    (mem_re),
        .idx   (commit_idx),
        .wdata (commit_wdata),
        .rdata (R_data)
    );

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder. Two instances run side by side:
// index 0 with two wait states, index 1 with none. A word-level model
// (array of words plus last read value) predicts R_data, Ready latency and Err.
module tb_mem_responder;

    localparam int ADDR_W = 10;

    logic        clk;
    logic        rst_n;
    logic        mem_rd [2];
    logic        mem_wr [2];
    logic [31:0] addr   [2];
    logic [31:0] wdata  [2];
    logic [31:0] r_data [2];
    logic        ready  [2];
`ifdef MEM_ALIGN_CHECK_EN
    logic        err    [2];
`endif

    bit [31:0] mdl_mem   [2][1024];
    bit [31:0] mdl_rdata [2];
    int        n_checks;
    int        n_fails;

    mem_responder #(.ADDR_W(ADDR_W), .WAIT_CYCLES(2)) dut_w2 (
        .clk    (clk),
        .rst_n  (rst_n),
        .MemRd  (mem_rd[0]),
        .MemWr  (mem_wr[0]),
        .Addr   (addr[0]),
        .W_data (wdata[0]),
        .R_data (r_data[0]),
        .Ready  (ready[0])
`ifdef MEM_ALIGN_CHECK_EN
        ,
        .Err    (err[0])
`endif
    );

    mem_responder #(.ADDR_W(ADDR_W), .WAIT_CYCLES(0)) dut_w0 (
        .clk    (clk),
        .rst_n  (rst_n),
        .MemRd  (mem_rd[1]),
        .MemWr  (mem_wr[1]),
        .Addr   (addr[1]),
        .W_data (wdata[1]),
        .R_data (r_data[1]),
        .Ready  (ready[1])
`ifdef MEM_ALIGN_CHECK_EN
        ,
        .Err    (err[1])
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int wait_of(input int s);
        return (s == 0) ? 2 : 0;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // One complete handshake on instance s: drive, hold until Ready, drop,
    // then compare latency, data, Err and the Ready pulse width.
    task automatic run_op(input int s, input logic rd, input logic wr,
                          input logic [31:0] a, input logic [31:0] d);
        int        lat;
        bit        got;
        bit        mis;
        bit [9:0]  idx;
        idx = a[11:2];
`ifdef MEM_ALIGN_CHECK_EN
        mis = (a[1:0] != 2'b00);
`else
        mis = 1'b0;
`endif
        if (!mis) begin
            if (wr) mdl_mem[s][idx] = d;
            else if (rd) mdl_rdata[s] = mdl_mem[s][idx];
        end

        @(negedge clk);
        mem_rd[s] = rd;
        mem_wr[s] = wr;
        addr[s]   = a;
        wdata[s]  = d;
        @(posedge clk);
        lat = 0;
        got = 1'b0;
        while (!got && lat < 20) begin
            @(negedge clk);
            if (ready[s]) begin
                got = 1'b1;
            end else begin
                lat++;
                addr[s]  = $urandom;
                wdata[s] = $urandom;
            end
        end
        mem_rd[s] = 1'b0;
        mem_wr[s] = 1'b0;
        check("ready_seen", 32'(got), 32'd1);
        if (got) begin
            check("latency", lat, wait_of(s));
            check("r_data", r_data[s], mdl_rdata[s]);
`ifdef MEM_ALIGN_CHECK_EN
            check("err", 32'(err[s]), 32'(mis));
`endif
        end
        @(negedge clk);
        check("ready_width", 32'(ready[s]), 32'd0);
`ifdef MEM_ALIGN_CHECK_EN
        check("err_width", 32'(err[s]), 32'd0);
`endif
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        n_checks = 0;
        n_fails  = 0;
        rst_n    = 1'b0;
        for (int s = 0; s < 2; s++) begin
            mem_rd[s] = 1'b0;
            mem_wr[s] = 1'b0;
            addr[s]   = '0;
            wdata[s]  = '0;
            mdl_rdata[s] = '0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            check("reset_ready", 32'(ready[s]), 32'd0);
            check("reset_r_data", r_data[s], 32'd0);
`ifdef MEM_ALIGN_CHECK_EN
            check("reset_err", 32'(err[s]), 32'd0);
`endif
        end
        rst_n = 1'b1;

        // Give every word the random traffic touches a known value.
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 32; i++) begin
                run_op(s, 1'b0, 1'b1, 32'(i) << 2, $urandom);
            end
        end

        // Write then read back with two wait states.
        run_op(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
        run_op(0, 1'b1, 1'b0, 32'h10, 32'h0);
        // Zero wait states.
        run_op(1, 1'b0, 1'b1, 32'h100, 32'h12345678);
        run_op(1, 1'b1, 1'b0, 32'h100, 32'h0);
        // Both requests high acts as a write and leaves R_data alone.
        run_op(0, 1'b1, 1'b1, 32'h20, 32'hA5A5A5A5);
        run_op(0, 1'b1, 1'b0, 32'h20, 32'h0);
        run_op(1, 1'b1, 1'b1, 32'h24, 32'h0BADF00D);
        run_op(1, 1'b1, 1'b0, 32'h24, 32'h0);
        // Upper address bits alias.
        run_op(0, 1'b0, 1'b1, 32'h1004, 32'h55);
        run_op(0, 1'b1, 1'b0, 32'h0004, 32'h0);
        // Misaligned write followed by an aligned read of the same word.
        run_op(0, 1'b0, 1'b1, 32'h42, 32'hFFFFFFFF);
        run_op(0, 1'b1, 1'b0, 32'h40, 32'h0);
        run_op(1, 1'b1, 1'b0, 32'h43, 32'h0);

        // Reset one edge after accepting a write: nothing is committed.
        run_op(0, 1'b0, 1'b1, 32'h30, 32'h0);
        @(negedge clk);
        mem_wr[0] = 1'b1;
        addr[0]   = 32'h30;
        wdata[0]  = 32'h11111111;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        mdl_rdata[0] = '0;
        mdl_rdata[1] = '0;
        check("abort_ready", 32'(ready[0]), 32'd0);
        check("abort_r_data", r_data[0], 32'd0);
        check("abort_r_data_w0", r_data[1], 32'd0);
        rst_n     = 1'b1;
        mem_wr[0] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("abort_idle", 32'(ready[0]), 32'd0);
        end
        run_op(0, 1'b1, 1'b0, 32'h30, 32'h0);

        // Random traffic over the preloaded window with aliased upper bits.
        for (int n = 0; n < 80; n++) begin
            logic [31:0] r;
            logic [1:0]  op;
            logic [4:0]  w;
            r  = $urandom;
            op = 2'($urandom_range(1, 3));
            w  = 5'($urandom_range(0, 31));
            run_op(n % 2, op[0], op[1], {r[31:12], 5'b0, w, r[1:0]}, $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Multi-cycle data/instruction memory slave. It is the responder end of the CPU's MemRd/MemWr/Addr/W_data/R_data memory interface.
- Adds a clocked request/Ready handshake, a configurable wait-state count and registered read data.
- Sits at the top level between the multicycle CPU datapath (IorD address mux, B register as write data) and the IR/MDR load points.
- The CPU control unit holds a request until Ready is seen.

Parameters:
- ADDR_W, 10, word-address bits; depth = 2**ADDR_W 32-bit words.
- WAIT_CYCLES, 2, extra clock edges between request accept and completion (0..15).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  reset, synchronous active-low.
- MemRd  input  1  read request; held by the CPU until Ready.
- MemWr  input  1  write request; held by the CPU until Ready.
- Addr  input  32  byte address; word index = Addr[ADDR_W+1:2].
- W_data  input  32  write data, sampled at the accept edge.
- R_data  output  32  registered read data.
- Ready  output  1  one-cycle completion pulse.
- Err  output  1  misalignment flag; present only with MEM_ALIGN_CHECK_EN.

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - State -> IDLE, wait counter = 0, R_data = 0, Ready = 0, Err = 0.
  - The memory array is not cleared.
- States: IDLE, WAIT, DONE.
- IDLE:
  - If MemRd|MemWr at an edge, accept the request.
  - On accept, latch op, word index and W_data; counter <= WAIT_CYCLES.
  - Next state is WAIT if WAIT_CYCLES>0, otherwise DONE.
  - MemWr and MemRd both high: treated as a write; R_data unchanged.
- WAIT:
  - Each edge decrements the counter.
  - At the edge where counter==1, go to DONE and commit.
  - Address/data input changes during WAIT are ignored (latched copy is used).
- Commit, at the IDLE/WAIT->DONE edge:
  - Write: mem[idx] <= latched W_data.
  - Read: R_data <= mem[idx].
- DONE:
  - Ready=1 for exactly this one cycle.
  - Next edge -> IDLE unconditionally; requests are not sampled in DONE.
- Latency: Ready is high in the cycle that starts WAIT_CYCLES edges after the accept edge (WAIT_CYCLES=0: the cycle right after accept).
- Back-to-back: a request still high in the IDLE cycle after DONE is a new request. The requester must drop MemRd/MemWr in the Ready cycle to avoid a repeat.
- R_data holds the last completed read until the next read commit; writes do not alter it.
- Address bits above ADDR_W+1 are ignored (aliasing).
- Reset mid-operation (WAIT or DONE): the request is aborted and no write is committed unless the commit edge already occurred.
- Ready and R_data are driven from flops only, with no combinational path from the inputs.

Optional Feature:
- Macro MEM_ALIGN_CHECK_EN.
- Defined:
  - Err port exists.
  - A request with latched Addr[1:0]!=0 still runs the full wait sequence.
  - At the commit edge the write is suppressed and R_data is unchanged.
  - Err=1 in the DONE cycle together with Ready; otherwise Err=0.
- Undefined:
  - No Err port.
  - Addr[1:0] is silently dropped; the access uses the word index.

Decomposition:
- Shared package mem_pkg holds:
  - WORD_W=32 and the byte-offset width constant (2);
  - the state typedef (IDLE/WAIT/DONE, 2-bit encoding);
  - the wait-counter width constant (4).
- One natural sub-module: mem_array, a single-port synchronous RAM.
  - Parameter ADDR_W; inputs clk, we, idx, wdata; output rdata, registered on the read-enable edge.
  - mem_responder instantiates it and owns the FSM, counter and handshake.

Test Plan:
- WAIT_CYCLES=2: write 0xDEADBEEF to Addr 0x10 (MemWr held until Ready), then read Addr 0x10 -> Ready exactly 2 edges after each accept, R_data=0xDEADBEEF, Ready width 1 cycle.
- WAIT_CYCLES=0: read from an address preloaded with 0x12345678 -> Ready in the cycle right after the accept edge, R_data=0x12345678.
- Both MemRd and MemWr high, W_data=0xA5A5A5A5, Addr 0x20 -> treated as write: R_data keeps its prior value; a subsequent read of 0x20 returns 0xA5A5A5A5.
- Reset mid-op:
  - Start a write of 0x11111111 to Addr 0x30 (old contents 0x0).
  - Assert rst_n=0 one edge after accept (WAIT_CYCLES=2).
  - Expected: Ready=0, R_data=0, state IDLE; a later read of 0x30 returns 0x0.
- Aliasing, ADDR_W=10: write 0x55 to Addr 0x1004, read Addr 0x0004 -> R_data=0x00000055.
- MEM_ALIGN_CHECK_EN defined:
  - Write 0xFFFFFFFF to Addr 0x42 -> Ready and Err high in the same single cycle.
  - A read of 0x40 returns the old value; an aligned access gives Err=0.
